// File: rtl/fetch_queue.sv
// fetch_queue: issues icache reads at cpc and queues {instr, npc} for decode; ihit -> id_valid next cycle.
// Backpressure: a full FIFO drops iREN and pcEn. Optional counters behind `ifdef FETCH_STATS_EN.
module fetch_queue #(
  parameter int         DEPTH   = 2,
  parameter logic [5:0] HALT_OP = 6'h3F
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [31:0] cpc,
  input  logic [31:0] npc,
  output logic        pcEn,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        ihit,
  input  logic [31:0] iload,
  input  logic        flush,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_npc,
  output logic        halted,
  output logic [31:0] stat_fetched,
  output logic [31:0] stat_stall
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic {FETCH, HALTED} state_t;

  state_t          r_state;
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic [31:0]     r_instr [DEPTH];
  logic [31:0]     r_npc   [DEPTH];

  logic w_full;
  logic w_push;
  logic w_pop;

  assign w_full = (r_count == CW'(DEPTH));

  // Gated by nRST so no request or PC load escapes while reset is held.
  assign iREN  = nRST & (r_state == FETCH) & ~w_full & ~flush;
  assign pcEn  = nRST & (flush | (iREN & ihit));
  assign iaddr = cpc;

  assign w_push = iREN & ihit;
  assign w_pop  = id_valid & id_ready;

  assign id_valid = (r_count != '0);
  assign id_instr = r_instr[r_rd_ptr];
  assign id_npc   = r_npc[r_rd_ptr];
  assign halted   = (r_state == HALTED);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state  <= FETCH;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_instr[i] <= '0;
        r_npc[i]   <= '0;
      end
    end else if (flush) begin
      // Redirect wins over any pop; stale entries stay in storage but are invalid.
      r_state  <= FETCH;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_instr[r_wr_ptr] <= iload;
        r_npc[r_wr_ptr]   <= npc;
        r_wr_ptr          <= r_wr_ptr + AW'(1);
        if (iload[31:26] == HALT_OP) begin
          r_state <= HALTED;
        end
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef FETCH_STATS_EN
  logic [31:0] r_stat_fetched;
  logic [31:0] r_stat_stall;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_stat_fetched <= '0;
      r_stat_stall   <= '0;
    end else begin
      if (w_push) begin
        r_stat_fetched <= r_stat_fetched + 32'd1;
      end
      if (iREN & ~ihit) begin
        r_stat_stall <= r_stat_stall + 32'd1;
      end
    end
  end

  assign stat_fetched = r_stat_fetched;
  assign stat_stall   = r_stat_stall;
`else
  assign stat_fetched = '0;
  assign stat_stall   = '0;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue (DEPTH=2): table of per-cycle vectors plus a hand-written async-reset sequence.
module tb_fetch_queue;

  logic        CLK = 1'b0;
  logic        nRST;
  logic [31:0] cpc, npc, iaddr, iload, id_instr, id_npc, stat_fetched, stat_stall;
  logic        pcEn, iREN, ihit, flush, id_valid, id_ready, halted;

  int n_chk  = 0;
  int n_fail = 0;

  fetch_queue #(.DEPTH(2), .HALT_OP(6'h3F)) dut (
    .CLK(CLK), .nRST(nRST), .cpc(cpc), .npc(npc), .pcEn(pcEn), .iREN(iREN),
    .iaddr(iaddr), .ihit(ihit), .iload(iload), .flush(flush), .id_valid(id_valid),
    .id_ready(id_ready), .id_instr(id_instr), .id_npc(id_npc), .halted(halted),
    .stat_fetched(stat_fetched), .stat_stall(stat_stall)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] cpc, npc, iload;
    logic        ihit, flush, rdy;
    logic        e_ren, e_pcen, e_vld;
    logic [31:0] e_instr, e_npc;
    logic        e_halt;
    logic [31:0] e_stall;
  } vec_t;

  localparam logic [31:0] HLT = 32'hFC00_0000;
  localparam logic [31:0] B0  = 32'h0B00_0000;
  localparam logic [31:0] C0  = 32'h0C00_0000;
  localparam logic [31:0] D0  = 32'h0D00_0000;

  function automatic logic [31:0] a_ins(input int n);
    return 32'h0A00_0000 + 32'(n);
  endfunction

  function automatic vec_t mk(input logic [31:0] c, input logic [31:0] n, input logic h,
                              input logic [31:0] ld, input logic f, input logic r,
                              input logic er, input logic ep, input logic ev,
                              input logic [31:0] ei, input logic [31:0] en,
                              input logic eh, input logic [31:0] es);
    vec_t v;
    v.cpc = c; v.npc = n; v.ihit = h; v.iload = ld; v.flush = f; v.rdy = r;
    v.e_ren = er; v.e_pcen = ep; v.e_vld = ev; v.e_instr = ei; v.e_npc = en;
    v.e_halt = eh; v.e_stall = es;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] c, input logic [31:0] n, input logic h,
                       input logic [31:0] ld, input logic f, input logic r);
    cpc = c; npc = n; ihit = h; iload = ld; flush = f; id_ready = r;
  endtask

  vec_t tv[22];

  initial begin
    // cpc, npc, ihit, iload, flush, rdy | iREN, pcEn, id_valid, instr, npc, halted, stat_stall
    tv[0]  = mk(32'h00, 32'h04, 1, a_ins(0), 0, 1, 1, 1, 0, 0, 0, 0, 0);
    tv[1]  = mk(32'h04, 32'h08, 1, a_ins(1), 0, 1, 1, 1, 1, a_ins(0), 32'h04, 0, 0);
    tv[2]  = mk(32'h08, 32'h0C, 1, a_ins(2), 0, 1, 1, 1, 1, a_ins(1), 32'h08, 0, 0);
    tv[3]  = mk(32'h0C, 32'h10, 1, a_ins(3), 0, 1, 1, 1, 1, a_ins(2), 32'h0C, 0, 0);
    tv[4]  = mk(32'h10, 32'h14, 0, 0,        0, 1, 1, 0, 1, a_ins(3), 32'h10, 0, 0);
    tv[5]  = mk(32'h10, 32'h14, 0, 0,        0, 1, 1, 0, 0, 0, 0, 0, 1);
    tv[6]  = mk(32'h10, 32'h14, 0, 0,        0, 1, 1, 0, 0, 0, 0, 0, 2);
    tv[7]  = mk(32'h10, 32'h14, 1, a_ins(4), 0, 1, 1, 1, 0, 0, 0, 0, 3);
    tv[8]  = mk(32'h14, 32'h18, 1, a_ins(5), 0, 0, 1, 1, 1, a_ins(4), 32'h14, 0, 3);
    tv[9]  = mk(32'h18, 32'h1C, 1, a_ins(6), 0, 0, 0, 0, 1, a_ins(4), 32'h14, 0, 3);
    tv[10] = mk(32'h18, 32'h1C, 1, a_ins(6), 0, 0, 0, 0, 1, a_ins(4), 32'h14, 0, 3);
    tv[11] = mk(32'h18, 32'h1C, 1, a_ins(6), 0, 1, 0, 0, 1, a_ins(4), 32'h14, 0, 3);
    tv[12] = mk(32'h18, 32'h1C, 1, a_ins(6), 0, 0, 1, 1, 1, a_ins(5), 32'h18, 0, 3);
    tv[13] = mk(32'h1C, 32'h20, 1, a_ins(7), 0, 0, 0, 0, 1, a_ins(5), 32'h18, 0, 3);
    tv[14] = mk(32'h1C, 32'h20, 1, a_ins(7), 1, 1, 0, 1, 1, a_ins(5), 32'h18, 0, 3);
    tv[15] = mk(32'h20, 32'h24, 1, HLT,      0, 0, 1, 1, 0, 0, 0, 0, 3);
    tv[16] = mk(32'h24, 32'h28, 1, a_ins(9), 0, 0, 0, 0, 1, HLT, 32'h24, 1, 3);
    tv[17] = mk(32'h24, 32'h28, 1, a_ins(9), 0, 1, 0, 0, 1, HLT, 32'h24, 1, 3);
    tv[18] = mk(32'h24, 32'h28, 0, 0,        0, 1, 0, 0, 0, 0, 0, 1, 3);
    tv[19] = mk(32'h24, 32'h28, 1, a_ins(9), 1, 1, 0, 1, 0, 0, 0, 1, 3);
    tv[20] = mk(32'h200, 32'h204, 1, C0,     0, 0, 1, 1, 0, 0, 0, 0, 3);
    tv[21] = mk(32'h204, 32'h208, 0, 0,      0, 0, 1, 0, 1, C0, 32'h204, 0, 3);

    nRST = 1'b0;
    drive(32'h0, 32'h4, 1'b1, 32'h0, 1'b0, 1'b1);
    repeat (2) @(negedge CLK);
    #1;
    chk("rst id_valid", 32'(id_valid), 0);
    chk("rst id_instr", id_instr, 0);
    chk("rst id_npc", id_npc, 0);
    chk("rst halted", 32'(halted), 0);
    chk("rst iREN", 32'(iREN), 0);
    chk("rst stat_fetched", stat_fetched, 0);
    chk("rst stat_stall", stat_stall, 0);
    @(negedge CLK);
    nRST = 1'b1;

    foreach (tv[k]) begin
      if (k != 0) @(negedge CLK);
      drive(tv[k].cpc, tv[k].npc, tv[k].ihit, tv[k].iload, tv[k].flush, tv[k].rdy);
      #1;
      chk($sformatf("v%0d iREN", k), 32'(iREN), 32'(tv[k].e_ren));
      chk($sformatf("v%0d pcEn", k), 32'(pcEn), 32'(tv[k].e_pcen));
      chk($sformatf("v%0d iaddr", k), iaddr, tv[k].cpc);
      chk($sformatf("v%0d id_valid", k), 32'(id_valid), 32'(tv[k].e_vld));
      chk($sformatf("v%0d halted", k), 32'(halted), 32'(tv[k].e_halt));
      if (tv[k].e_vld) begin
        chk($sformatf("v%0d id_instr", k), id_instr, tv[k].e_instr);
        chk($sformatf("v%0d id_npc", k), id_npc, tv[k].e_npc);
      end
`ifdef FETCH_STATS_EN
      chk($sformatf("v%0d stat_stall", k), stat_stall, tv[k].e_stall);
`else
      chk($sformatf("v%0d stat_stall", k), stat_stall, 0);
`endif
    end

    // Reset asserted mid-cycle with a pending miss and one queued entry.
    @(negedge CLK);
    drive(32'h204, 32'h208, 1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    chk("pre-rst iREN", 32'(iREN), 1);
    chk("pre-rst id_valid", 32'(id_valid), 1);
    chk("pre-rst id_instr", id_instr, C0);
`ifdef FETCH_STATS_EN
    chk("pre-rst stat_fetched", stat_fetched, 9);
    chk("pre-rst stat_stall", stat_stall, 4);
`else
    chk("pre-rst stat_fetched", stat_fetched, 0);
`endif
    #1 nRST = 1'b0;
    #1;
    chk("async id_valid", 32'(id_valid), 0);
    chk("async id_instr", id_instr, 0);
    chk("async id_npc", id_npc, 0);
    chk("async halted", 32'(halted), 0);
    chk("async iREN", 32'(iREN), 0);
    chk("async stat_fetched", stat_fetched, 0);
    chk("async stat_stall", stat_stall, 0);

    @(negedge CLK);
    nRST = 1'b1;
    #1;
    chk("post-rst iREN", 32'(iREN), 1);
    chk("post-rst pcEn", 32'(pcEn), 0);
    chk("post-rst id_valid", 32'(id_valid), 0);
    @(negedge CLK);
    drive(32'h204, 32'h208, 1'b1, D0, 1'b0, 1'b0);
    #1;
    chk("post-rst hit pcEn", 32'(pcEn), 1);
    @(negedge CLK);
    drive(32'h208, 32'h20C, 1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    chk("post-rst id_valid", 32'(id_valid), 1);
    chk("post-rst id_instr", id_instr, D0);
    chk("post-rst id_npc", id_npc, 32'h208);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
